iir_biquad_mc: RTL and testbench
================================

// Module: iir_biquad_mc
// PURPOSE
//  Multi-channel, time-multiplexed second-order IIR (biquad, direct form I) filter with runtime-loadable
//  per-channel coefficients. Successor to the fixed first-order DigitalFilter: one shared multiplier,
//  valid/ready input, per-channel history. Sits between the sample source (ROM/ADC) and output capture.
// PARAMETERS
//  NUM_CH     4   number of independent channels (>=1)
//  DATA_W     32  signed sample width (data_in, yn)
//  COEF_W     32  signed coefficient width
//  FRAC_BITS  16  fractional bits of coefficients (Q(COEF_W-FRAC_BITS).FRAC_BITS)
// PORTS
//  clk         in   1                 clock, rising edge
//  rst         in   1                 asynchronous reset, active-high
//  in_valid    in   1                 sample offered
//  in_ready    out  1                 block can accept sample (high only in IDLE)
//  in_ch       in   $clog2(NUM_CH)    channel of offered sample
//  data_in     in   DATA_W            signed sample x[n]
//  coef_we     in   1                 coefficient write strobe
//  coef_ch     in   $clog2(NUM_CH)    channel of coefficient write
//  coef_idx    in   3                 0=b0 1=b1 2=b2 3=a1 4=a2; 5..7 ignored
//  coef_wdata  in   COEF_W            signed coefficient value
//  coef_err    out  1                 one-cycle pulse: write rejected
//  clr         in   1                 synchronous clear of all history, aborts current sample
//  out_valid   out  1                 one-cycle pulse, yn/out_ch valid
//  out_ch      out  $clog2(NUM_CH)    channel of yn
//  yn          out  DATA_W            signed output y[n]
// BEHAVIOUR
//  - y = (b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2 + 2^(FRAC_BITS-1)) >>> FRAC_BITS; ACC_W = DATA_W+COEF_W+3.
//  - Reset: state IDLE, in_ready=1, out_valid=0, coef_err=0, out_ch=0, yn=0, all coefs and history 0.
//  - FSM IDLE -> MAC (5 cycles, term counter 0..4, one product/cycle) -> RND -> IDLE.
//  - Handshake in cycle T (in_valid & in_ready): latch x, ch. MAC T+1..T+5, RND T+6, out_valid=1 in T+7.
//    in_ready high again in T+7: max throughput 1 sample / 7 cycles; in_valid held low is a no-op.
//  - RND: round, clamp/wrap to DATA_W, register yn/out_ch; history of that ch: x2<=x1, x1<=x, y2<=y1, y1<=yn.
//  - in_ch >= NUM_CH: sample accepted, no output, no state change, FSM stays IDLE.
//  - Coef write accepted only in IDLE and coef_ch < NUM_CH and coef_idx <= 4, takes effect on next accepted
//    sample; otherwise dropped and coef_err pulses next cycle. Write and sample in same IDLE cycle: write
//    lands first (sample uses new coef).
//  - clr: any state -> IDLE next cycle; all history zeroed; in-flight sample produces no out_valid; coefs kept.
//    clr has priority over a same-cycle handshake (sample dropped).
//  - rst mid-operation: immediate return to reset values; no out_valid.
// CONFIGURATION
//  SATURATE_EN defined: RND clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; y1 stores the clamped value.
//  SATURATE_EN undefined: RND keeps the low DATA_W bits (two's-complement wrap).
// STRUCTURE
//  Package iir_pkg: typedef state_e {IDLE,MAC,RND}; typedef coef_idx_e {B0,B1,B2,A1,A2}; NUM_TERMS=5.
//  Sub-module iir_mac: signed DATA_W x COEF_W multiplier + ACC_W accumulator with clear/add/sub control.
//  Top holds FSM, coef bank [NUM_CH][5], history regs [NUM_CH][4], rounding/saturation.
// TESTING (FRAC_BITS=16, DATA_W=COEF_W=32)
//  1 Pass-through: ch0 b0=0x10000, rest 0; x=1234 at T -> out_valid at T+7, yn=1234, out_ch=0.
//  2 FIR: ch1 b0=b1=0x8000; impulse 0x10000 then 0,0 -> yn 0x8000, 0x8000, 0.
//  3 Feedback: ch2 b0=0x10000, a1=0xFFFF8000 (-0.5); step x=0x1000 x3 -> yn 0x1000, 0x1800, 0x1C00.
//  4 Isolation: interleave ch1/ch2 samples of tests 2/3 -> identical per-channel sequences; coef write
//    during MAC -> coef_err pulse, coefs unchanged.
//  5 Overflow: b0=0x20000, x=0x7FFFFFFF -> yn 0x7FFFFFFF with SATURATE_EN, 0xFFFFFFFE without.
//  6 Abort: clr at T+3 -> no out_valid, in_ready at T+4, next sample sees zero history; rst at T+4 same.

Source files
------------

// File: rtl/iir_pkg.sv
// iir_pkg: shared state/term encodings and constants for the iir_biquad_mc biquad filter.
package iir_pkg;

    typedef enum logic [1:0] {IDLE, MAC, RND} state_e;

    // Term order doubles as the MAC schedule and the coefficient-bank index.
    typedef enum logic [2:0] {B0, B1, B2, A1, A2} coef_idx_e;

    localparam int NUM_TERMS = 5;

endpackage

// File: rtl/iir_mac.sv
// iir_mac: shared signed multiplier feeding a wide accumulator; one product per enabled cycle.
module iir_mac #(
    parameter int  DATA_W = 32,
    parameter int  COEF_W = 32,
    localparam int ACC_W  = DATA_W + COEF_W + 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     load_i,
    input  logic                     sub_i,
    input  logic signed [DATA_W-1:0] a_i,
    input  logic signed [COEF_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [DATA_W+COEF_W-1:0] prod;
    logic signed [ACC_W-1:0]         prodExt;
    logic signed [ACC_W-1:0]         base;
    logic signed [ACC_W-1:0]         acc_d;
    logic signed [ACC_W-1:0]         acc_q;

    assign prod    = a_i * b_i;
    assign prodExt = ACC_W'(prod);

    // load_i starts a fresh sum so no separate clear cycle is needed.
    assign base  = load_i ? '0 : acc_q;
    assign acc_d = sub_i ? (base - prodExt) : (base + prodExt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/iir_biquad_mc.sv
// iir_biquad_mc: time-multiplexed multi-channel direct-form-I biquad with loadable coefficients.
// Define SATURATE_EN to clamp the output; otherwise the output wraps to DATA_W bits.
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int  NUM_CH    = 4,
    parameter int  DATA_W    = 32,
    parameter int  COEF_W    = 32,
    parameter int  FRAC_BITS = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     coef_we,
    input  logic [CH_W-1:0]          coef_ch,
    input  logic [2:0]               coef_idx,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     coef_err,
    input  logic                     clr,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] yn
);

    localparam int ACC_W = DATA_W + COEF_W + 3;
    localparam logic signed [ACC_W-1:0] RND_HALF = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    state_e                   state_q;
    coef_idx_e                term_q;
    logic [CH_W-1:0]          ch_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [COEF_W-1:0] coef_q [NUM_CH][NUM_TERMS];
    logic signed [DATA_W-1:0] x1_q [NUM_CH];
    logic signed [DATA_W-1:0] x2_q [NUM_CH];
    logic signed [DATA_W-1:0] y1_q [NUM_CH];
    logic signed [DATA_W-1:0] y2_q [NUM_CH];
    logic                     out_valid_q;
    logic [CH_W-1:0]          out_ch_q;
    logic signed [DATA_W-1:0] yn_q;
    logic                     coef_err_q;

    logic                     inChOk;
    logic                     coefChOk;
    logic                     coefOk;
    logic signed [DATA_W-1:0] macA;
    logic signed [COEF_W-1:0] macB;
    logic                     macSub;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  rndSum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [DATA_W-1:0] yn_d;

    // Channel range checks only exist when the index width can name a missing channel.
    if ((1 << CH_W) > NUM_CH) begin : gChCheck
        assign inChOk   = int'(in_ch) < NUM_CH;
        assign coefChOk = int'(coef_ch) < NUM_CH;
    end else begin : gChAll
        assign inChOk   = 1'b1;
        assign coefChOk = 1'b1;
    end

    assign coefOk = coef_we && (state_q == IDLE) && coefChOk && (coef_idx <= 3'd4);

    always_comb begin
        macA   = x_q;
        macB   = coef_q[ch_q][B0];
        macSub = 1'b0;
        unique case (term_q)
            B0: begin macA = x_q;        macB = coef_q[ch_q][B0]; end
            B1: begin macA = x1_q[ch_q]; macB = coef_q[ch_q][B1]; end
            B2: begin macA = x2_q[ch_q]; macB = coef_q[ch_q][B2]; end
            A1: begin macA = y1_q[ch_q]; macB = coef_q[ch_q][A1]; macSub = 1'b1; end
            A2: begin macA = y2_q[ch_q]; macB = coef_q[ch_q][A2]; macSub = 1'b1; end
            default: ;
        endcase
    end

    iir_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W)
    ) uMac (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == MAC),
        .load_i (term_q == B0),
        .sub_i  (macSub),
        .a_i    (macA),
        .b_i    (macB),
        .acc_o  (acc)
    );

    assign rndSum  = acc + RND_HALF;
    assign shifted = rndSum >>> FRAC_BITS;

`ifdef SATURATE_EN
    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    always_comb begin
        yn_d = shifted[DATA_W-1:0];
        if (shifted > Y_MAX) begin
            yn_d = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (shifted < Y_MIN) begin
            yn_d = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
`else
    logic unusedHi;
    assign yn_d     = shifted[DATA_W-1:0];
    assign unusedHi = ^shifted[ACC_W-1:DATA_W];
`endif

    // clr wins over everything in the datapath but leaves coefficient writes alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            term_q      <= B0;
            ch_q        <= '0;
            x_q         <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            yn_q        <= '0;
            coef_err_q  <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                x1_q[c] <= '0;
                x2_q[c] <= '0;
                y1_q[c] <= '0;
                y2_q[c] <= '0;
                for (int t = 0; t < NUM_TERMS; t++) begin
                    coef_q[c][t] <= '0;
                end
            end
        end else begin
            out_valid_q <= 1'b0;
            coef_err_q  <= coef_we && !coefOk;
            if (coefOk) begin
                coef_q[coef_ch][coef_idx] <= coef_wdata;
            end
            if (clr) begin
                state_q <= IDLE;
                term_q  <= B0;
                for (int c = 0; c < NUM_CH; c++) begin
                    x1_q[c] <= '0;
                    x2_q[c] <= '0;
                    y1_q[c] <= '0;
                    y2_q[c] <= '0;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (in_valid && inChOk) begin
                            state_q <= MAC;
                            term_q  <= B0;
                            x_q     <= data_in;
                            ch_q    <= in_ch;
                        end
                    end
                    MAC: begin
                        if (term_q == A2) begin
                            state_q <= RND;
                        end else begin
                            term_q <= coef_idx_e'(term_q + 3'd1);
                        end
                    end
                    RND: begin
                        state_q     <= IDLE;
                        term_q      <= B0;
                        out_valid_q <= 1'b1;
                        out_ch_q    <= ch_q;
                        yn_q        <= yn_d;
                        x2_q[ch_q]  <= x1_q[ch_q];
                        x1_q[ch_q]  <= x_q;
                        y2_q[ch_q]  <= y1_q[ch_q];
                        y1_q[ch_q]  <= yn_d;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign yn        = yn_q;
    assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_iir_biquad_mc.sv
// tb_iir_biquad_mc: directed and randomized checks of iir_biquad_mc against an arithmetic biquad model.
// Honours SATURATE_EN the same way the design does.
module tb_iir_biquad_mc;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [1:0]         in_ch;
    logic signed [31:0] data_in;
    logic               coef_we;
    logic [1:0]         coef_ch;
    logic [2:0]         coef_idx;
    logic signed [31:0] coef_wdata;
    logic               coef_err;
    logic               clr;
    logic               out_valid;
    logic [1:0]         out_ch;
    logic signed [31:0] yn;

    int compared;
    int mismatched;

    // Reference state: coefficients and per-channel history as the filter equation sees them.
    logic signed [31:0] mCoef [4][5];
    logic signed [31:0] mX1 [4];
    logic signed [31:0] mX2 [4];
    logic signed [31:0] mY1 [4];
    logic signed [31:0] mY2 [4];

    iir_biquad_mc #(
        .NUM_CH    (4),
        .DATA_W    (32),
        .COEF_W    (32),
        .FRAC_BITS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ch      (in_ch),
        .data_in    (data_in),
        .coef_we    (coef_we),
        .coef_ch    (coef_ch),
        .coef_idx   (coef_idx),
        .coef_wdata (coef_wdata),
        .coef_err   (coef_err),
        .clr        (clr),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .yn         (yn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [127:0] wide(input logic signed [31:0] v);
        return v;
    endfunction

    function automatic logic [31:0] modelY(input int ch, input logic signed [31:0] x);
        logic signed [127:0] s;
        s = wide(mCoef[ch][0]) * wide(x) + wide(mCoef[ch][1]) * wide(mX1[ch])
          + wide(mCoef[ch][2]) * wide(mX2[ch]) - wide(mCoef[ch][3]) * wide(mY1[ch])
          - wide(mCoef[ch][4]) * wide(mY2[ch]);
        s = (s + 128'sd32768) >>> 16;
`ifdef SATURATE_EN
        if (s > 128'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -128'sd2147483648) return 32'h8000_0000;
`endif
        return s[31:0];
    endfunction

    task automatic clearHistory();
        for (int c = 0; c < 4; c++) begin
            mX1[c] = '0;
            mX2[c] = '0;
            mY1[c] = '0;
            mY2[c] = '0;
        end
    endtask

    task automatic clearCoefs();
        for (int c = 0; c < 4; c++) begin
            for (int t = 0; t < 5; t++) mCoef[c][t] = '0;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issued from a negedge while the filter is idle.
    task automatic writeCoef(input int ch, input int idx, input logic [31:0] val);
        coef_we    = 1'b1;
        coef_ch    = 2'(ch);
        coef_idx   = 3'(idx);
        coef_wdata = val;
        @(negedge clk);
        coef_we = 1'b0;
        if (idx <= 4) begin
            mCoef[ch][idx] = val;
            checkOutput("coefErrGood", 64'(coef_err), 64'd0);
        end else begin
            checkOutput("coefErrBadIdx", 64'(coef_err), 64'd1);
        end
        @(negedge clk);
        checkOutput("coefErrPulse", 64'(coef_err), 64'd0);
    endtask

    // One sample with optional clr / rst / illegal coefficient write injected n cycles after the handshake.
    task automatic applyStimulus(input int ch, input logic [31:0] x, input int clrAt, input int rstAt,
                                 input int badWrAt, output logic [31:0] yOut);
        int          firstValid;
        int          pulses;
        logic [31:0] ynSeen;
        logic [1:0]  chSeen;
        logic [31:0] yExp;
        firstValid = 0;
        pulses     = 0;
        ynSeen     = '0;
        chSeen     = '0;
        checkOutput("readyBefore", 64'(in_ready), 64'd1);
        yExp     = modelY(ch, x);
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        data_in  = x;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin
                in_valid = 1'b0;
                if (coef_we) begin
                    coef_we = 1'b0;
                    checkOutput("coefSameCycleErr", 64'(coef_err), 64'd0);
                end
            end
            if (clr) clr = 1'b0;
            if (coef_we) begin
                coef_we = 1'b0;
                checkOutput("coefBusyErr", 64'(coef_err), 64'd1);
            end
            if (rst) begin
                checkOutput("rstYn", 64'(yn), 64'd0);
                checkOutput("rstOutCh", 64'(out_ch), 64'd0);
                checkOutput("rstReady", 64'(in_ready), 64'd1);
                rst = 1'b0;
            end
            if (out_valid) begin
                pulses++;
                if (firstValid == 0) begin
                    firstValid = n;
                    ynSeen     = yn;
                    chSeen     = out_ch;
                end
            end
            if (n == 6 && clrAt == 0 && rstAt == 0) checkOutput("busyReady", 64'(in_ready), 64'd0);
            if (clrAt > 0 && n == clrAt + 1) checkOutput("clrReady", 64'(in_ready), 64'd1);
            if (n == clrAt) clr = 1'b1;
            if (n == rstAt) rst = 1'b1;
            if (n == badWrAt) begin
                coef_we    = 1'b1;
                coef_ch    = 2'(ch);
                coef_idx   = 3'd0;
                coef_wdata = 32'h0001_2345;
            end
        end
        yOut = ynSeen;
        if (clrAt > 0 || rstAt > 0) begin
            checkOutput("abortNoValid", 64'(pulses), 64'd0);
            clearHistory();
            if (rstAt > 0) clearCoefs();
        end else begin
            checkOutput("latency", 64'(firstValid), 64'd7);
            checkOutput("pulseCount", 64'(pulses), 64'd1);
            checkOutput("ynModel", 64'(ynSeen), 64'(yExp));
            checkOutput("outCh", 64'(chSeen), 64'(ch));
            mX2[ch] = mX1[ch];
            mX1[ch] = x;
            mY2[ch] = mY1[ch];
            mY1[ch] = yExp;
        end
    endtask

    // A clr in the same cycle as a handshake must swallow the sample.
    task automatic dropSample(input int ch, input logic [31:0] x);
        int pulses;
        pulses   = 0;
        in_valid = 1'b1;
        in_ch    = 2'(ch);
        data_in  = x;
        clr      = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        clr      = 1'b0;
        checkOutput("dropReady", 64'(in_ready), 64'd1);
        for (int n = 0; n < 9; n++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        checkOutput("dropNoValid", 64'(pulses), 64'd0);
        clearHistory();
    endtask

    initial begin
        logic [31:0] y;
        logic [31:0] rx;
        logic [31:0] rc;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_ch      = '0;
        data_in    = '0;
        coef_we    = 1'b0;
        coef_ch    = '0;
        coef_idx   = '0;
        coef_wdata = '0;
        clr        = 1'b0;
        clearCoefs();
        clearHistory();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetReady", 64'(in_ready), 64'd1);
        checkOutput("resetValid", 64'(out_valid), 64'd0);
        checkOutput("resetCoefErr", 64'(coef_err), 64'd0);
        checkOutput("resetOutCh", 64'(out_ch), 64'd0);
        checkOutput("resetYn", 64'(yn), 64'd0);

        // Pass-through on ch0.
        writeCoef(0, 0, 32'h0001_0000);
        applyStimulus(0, 32'd1234, 0, 0, 0, y);
        checkOutput("passYn", 64'(y), 64'd1234);

        // Two-tap FIR on ch1.
        writeCoef(1, 0, 32'h0000_8000);
        writeCoef(1, 1, 32'h0000_8000);
        applyStimulus(1, 32'h0001_0000, 0, 0, 0, y);
        checkOutput("firY0", 64'(y), 64'h8000);
        applyStimulus(1, 32'h0, 0, 0, 0, y);
        checkOutput("firY1", 64'(y), 64'h8000);
        applyStimulus(1, 32'h0, 0, 0, 0, y);
        checkOutput("firY2", 64'(y), 64'h0);

        // First-order feedback on ch2.
        writeCoef(2, 0, 32'h0001_0000);
        writeCoef(2, 3, 32'hFFFF_8000);
        applyStimulus(2, 32'h1000, 0, 0, 0, y);
        checkOutput("fbY0", 64'(y), 64'h1000);
        applyStimulus(2, 32'h1000, 0, 0, 0, y);
        checkOutput("fbY1", 64'(y), 64'h1800);
        applyStimulus(2, 32'h1000, 0, 0, 0, y);
        checkOutput("fbY2", 64'(y), 64'h1C00);

        // Idle clr, then interleaved channels with an illegal write during MAC.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        clearHistory();
        applyStimulus(1, 32'h0001_0000, 0, 0, 0, y);
        checkOutput("ilvFir0", 64'(y), 64'h8000);
        applyStimulus(2, 32'h1000, 0, 0, 2, y);
        checkOutput("ilvFb0", 64'(y), 64'h1000);
        applyStimulus(1, 32'h0, 0, 0, 0, y);
        checkOutput("ilvFir1", 64'(y), 64'h8000);
        applyStimulus(2, 32'h1000, 0, 0, 0, y);
        checkOutput("ilvFb1", 64'(y), 64'h1800);
        applyStimulus(1, 32'h0, 0, 0, 0, y);
        checkOutput("ilvFir2", 64'(y), 64'h0);
        applyStimulus(2, 32'h1000, 0, 0, 0, y);
        checkOutput("ilvFb2", 64'(y), 64'h1C00);

        // Out-of-range coefficient indices.
        writeCoef(0, 5, 32'h0000_DEAD);
        writeCoef(0, 7, 32'h0000_BEEF);

        // Overflow on ch3.
        writeCoef(3, 0, 32'h0002_0000);
        applyStimulus(3, 32'h7FFF_FFFF, 0, 0, 0, y);
`ifdef SATURATE_EN
        checkOutput("overflowYn", 64'(y), 64'h7FFF_FFFF);
`else
        checkOutput("overflowYn", 64'(y), 64'hFFFF_FFFE);
`endif

        // Coefficient write in the handshake cycle is used by that sample.
        coef_we    = 1'b1;
        coef_ch    = 2'd3;
        coef_idx   = 3'd0;
        coef_wdata = 32'h0003_0000;
        mCoef[3][0] = 32'h0003_0000;
        applyStimulus(3, 32'd100, 0, 0, 0, y);
        checkOutput("sameCycleCoef", 64'(y), 64'd300);

        // clr abort on ch0 with y = x + x1.
        writeCoef(0, 1, 32'h0001_0000);
        applyStimulus(0, 32'd100, 0, 0, 0, y);
        applyStimulus(0, 32'd200, 0, 0, 0, y);
        checkOutput("histSum", 64'(y), 64'd300);
        applyStimulus(0, 32'd500, 3, 0, 0, y);
        applyStimulus(0, 32'd7, 0, 0, 0, y);
        checkOutput("postClrYn", 64'(y), 64'd7);

        // rst abort, coefficients come back zero.
        applyStimulus(0, 32'd9, 0, 4, 0, y);
        writeCoef(0, 0, 32'h0001_0000);
        writeCoef(0, 1, 32'h0001_0000);
        applyStimulus(0, 32'd11, 0, 0, 0, y);
        checkOutput("postRstYn", 64'(y), 64'd11);

        dropSample(1, 32'd50);

        // Randomized coefficients, channels and samples against the model.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                rc = 32'($urandom_range(0, 98304)) - 32'd49152;
                writeCoef(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), rc);
            end
            rx = $urandom;
            if ($urandom_range(0, 3) != 0) rx = 32'($urandom_range(0, 200000)) - 32'd100000;
            applyStimulus(int'($urandom_range(0, 3)), rx, 0, 0, 0, y);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
